action_dispatcher: RTL and testbench
====================================

Name: action_dispatcher

Overview:
- Sits directly upstream of the primitive executor.
- Accepts match results (action id + packet id) from the match stage and buffers them in a small FIFO.
- Translates each action id into an action-program start address through a configurable pointer table, then runs a four-phase start/done handshake with the executor.
- Reports per-packet completion status to the downstream output stage.

Parameters:
ACT_W, 4, action id width; pointer table has 2^ACT_W entries
ID_W, 8, packet id width
FIFO_DEPTH, 4, match-result FIFO depth (power of 2, >=2)
TIMEOUT, 1024, max cycles waiting on any executor handshake edge before abort

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
match_valid_i  in  1  match result valid
match_ready_o  out  1  FIFO not full
match_action_i  in  ACT_W  action id
match_pkt_id_i  in  ID_W  packet id
cfg_we_i  in  1  pointer table write strobe
cfg_idx_i  in  ACT_W  table index
cfg_addr_i  in  32  program start address
cfg_valid_i  in  1  entry valid bit written with address
exec_start_o  out  1  executor start (level)
exec_start_addr_o  out  32  program start address
exec_done_i  in  1  executor done (level)
out_valid_o  out  1  completion record valid
out_ready_i  in  1  downstream accepts record
out_pkt_id_o  out  ID_W  completed packet id
out_status_o  out  2  00 ok, 01 no action, 10 timeout

Behaviour:
- Reset values:
  - exec_start_o=0, exec_start_addr_o=0, out_valid_o=0, out_pkt_id_o=0, out_status_o=0.
  - match_ready_o=1.
  - FIFO empty, all table valid bits 0, state IDLE, timeout counter 0.
- Reset mid-operation aborts everything: it drops exec_start_o immediately, and the executor returns to free on start low.
- FIFO:
  - Push on match_valid_i & match_ready_o.
  - match_ready_o = !full, registered from occupancy.
  - Simultaneous push and pop when full is not accepted, because ready is already low.
  - Simultaneous push and pop when non-empty keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Pointer table:
  - Written on cfg_we_i in any state. Read is combinational.
  - A write to the entry in use does not affect an already-latched exec_start_addr_o.
- State machine:
  - IDLE: if FIFO non-empty, pop the head and latch pkt_id.
    - Entry valid: latch the address into exec_start_addr_o, set exec_start_o=1, go to WAIT_DONE.
    - Entry invalid: status=01, go to OUTPUT. The executor is never started.
    - Latency from pop to exec_start_o high is 1 cycle.
  - WAIT_DONE: hold exec_start_o=1 and the address stable.
    - On exec_done_i=1: exec_start_o<=0, status=00, go to RELEASE.
    - If the counter reaches TIMEOUT-1: exec_start_o<=0, status=10, go to RELEASE.
  - RELEASE: wait for exec_done_i=0, then go to OUTPUT.
    - If done stays high for TIMEOUT cycles, force status=10 and go to OUTPUT.
    - This wait also holds off the next start.
  - OUTPUT: out_valid_o=1 with pkt_id/status held stable until out_ready_i.
    - On acceptance: out_valid_o<=0, return to IDLE.
    - At most one packet is in flight; the earliest next start is 1 cycle after acceptance.
- Timeout counter:
  - Cleared on every state entry, increments each cycle in WAIT_DONE/RELEASE, saturates, never wraps.
- exec_done_i high while in IDLE or OUTPUT is ignored.
- Downstream backpressure in OUTPUT does not stall FIFO pushes until the FIFO is full.

Test Plan:
1. Normal run:
   - Stimulus: write idx 3 = 0x0000_0100 valid; push action 3, pkt 0x21; executor model raises done 20 cycles after start and drops it 2 cycles after start low.
   - Required response: start high 1 cycle after push, addr 0x100, start low the cycle after done; out_valid with pkt 0x21 status 00; executor never started twice.
2. Invalid entry:
   - Stimulus: push action 5 with its entry unwritten.
   - Required response: exec_start_o stays 0; out record pkt id, status 01, within 3 cycles.
3. FIFO full and backpressure:
   - Stimulus: hold out_ready_i=0; push 6 results.
   - Required response: match_ready_o drops after 1 in flight + 4 buffered; on release of out_ready_i, records emerge in push order with no loss or duplication.
4. Timeout:
   - Stimulus: exec_done_i stuck 0.
   - Required response: start drops after TIMEOUT cycles; status 10; next packet dispatched afterwards.
5. Done never releases:
   - Stimulus: exec_done_i stuck 1 after the first packet.
   - Required response: first packet status 10 after the RELEASE timeout; no spurious instant completion for the next packet.
6. Reset mid-WAIT_DONE:
   - Stimulus: assert rst for 1 cycle during WAIT_DONE.
   - Required response: all outputs return to reset values next cycle, FIFO empty, table invalidated.

Source files
------------

// File: rtl/action_dispatcher.sv
// Action dispatcher: buffers match results, maps action ids to program start
// addresses, runs a four-phase start/done handshake with the executor, and reports completion.
module action_dispatcher #(
  parameter int ACT_W      = 4,
  parameter int ID_W       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              match_valid_i,
  output logic              match_ready_o,
  input  logic [ACT_W-1:0]  match_action_i,
  input  logic [ID_W-1:0]   match_pkt_id_i,
  input  logic              cfg_we_i,
  input  logic [ACT_W-1:0]  cfg_idx_i,
  input  logic [31:0]       cfg_addr_i,
  input  logic              cfg_valid_i,
  output logic              exec_start_o,
  output logic [31:0]       exec_start_addr_o,
  input  logic              exec_done_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ID_W-1:0]   out_pkt_id_o,
  output logic [1:0]        out_status_o,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid and its payload never change while waiting for ready.

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TBL_N = 1 << ACT_W;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NO_ACT  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_RELEASE   = 2'd2,
    S_OUTPUT    = 2'd3
  } state_t;

  // Match-result FIFO
  logic [ACT_W-1:0] r_fifo_act [FIFO_DEPTH];
  logic [ID_W-1:0]  r_fifo_id  [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_match_ready;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_next;

  // Pointer table
  logic [31:0]      r_tbl_addr [TBL_N];
  logic [TBL_N-1:0] r_tbl_valid;

  logic [ACT_W-1:0] w_head_act;
  logic [ID_W-1:0]  w_head_id;
  logic             w_head_valid;
  logic [31:0]      w_head_addr;

  // Dispatch FSM
  state_t           r_state;
  logic             r_start;
  logic [31:0]      r_addr;
  logic             r_out_valid;
  logic [ID_W-1:0]  r_pkt_id;
  logic [1:0]       r_status;
  logic [TMR_W-1:0] r_timer;
  logic             w_tmr_last;

  assign w_push = match_valid_i & r_match_ready;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_match_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count       <= w_count_next;
      r_match_ready <= (w_count_next != CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_act[r_wr_ptr] <= match_action_i;
      r_fifo_id[r_wr_ptr]  <= match_pkt_id_i;
    end
  end

  // Addresses need no reset: an entry is only used once its valid bit is set.
  always_ff @(posedge clk) begin
    if (cfg_we_i) r_tbl_addr[cfg_idx_i] <= cfg_addr_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tbl_valid <= '0;
    end else if (cfg_we_i) begin
      r_tbl_valid[cfg_idx_i] <= cfg_valid_i;
    end
  end

  assign w_head_act   = r_fifo_act[r_rd_ptr];
  assign w_head_id    = r_fifo_id[r_rd_ptr];
  assign w_head_valid = r_tbl_valid[w_head_act];
  assign w_head_addr  = r_tbl_addr[w_head_act];

  assign w_tmr_last = (r_timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_start     <= 1'b0;
      r_addr      <= '0;
      r_out_valid <= 1'b0;
      r_pkt_id    <= '0;
      r_status    <= ST_OK;
      r_timer     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_pkt_id <= w_head_id;
            r_timer  <= '0;
            if (w_head_valid) begin
              r_addr  <= w_head_addr;
              r_start <= 1'b1;
              r_state <= S_WAIT_DONE;
            end else begin
              r_status    <= ST_NO_ACT;
              r_out_valid <= 1'b1;
              r_state     <= S_OUTPUT;
            end
          end
        end

        S_WAIT_DONE: begin
          if (exec_done_i) begin
            r_start  <= 1'b0;
            r_status <= ST_OK;
            r_timer  <= '0;
            r_state  <= S_RELEASE;
          end else if (w_tmr_last) begin
            r_start  <= 1'b0;
            r_status <= ST_TIMEOUT;
            r_timer  <= '0;
            r_state  <= S_RELEASE;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        // Executor must drop done before the next start can be issued.
        S_RELEASE: begin
          if (!exec_done_i) begin
            r_out_valid <= 1'b1;
            r_timer     <= '0;
            r_state     <= S_OUTPUT;
          end else if (w_tmr_last) begin
            r_status    <= ST_TIMEOUT;
            r_out_valid <= 1'b1;
            r_timer     <= '0;
            r_state     <= S_OUTPUT;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        S_OUTPUT: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_timer     <= '0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b0;
        end
      endcase
    end
  end

  assign match_ready_o     = r_match_ready;
  assign exec_start_o      = r_start;
  assign exec_start_addr_o = r_addr;
  assign out_valid_o       = r_out_valid;
  assign out_pkt_id_o      = r_pkt_id;
  assign out_status_o      = r_status;
  assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_action_dispatcher.sv
// Bench for action_dispatcher: directed scenarios plus a random phase, with a
// scoreboard of expected completion records and start addresses.
module tb_action_dispatcher;

  localparam int ACT_W      = 4;
  localparam int ID_W       = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 1024;

  logic              clk;
  logic              rst;
  logic              match_valid;
  logic              match_ready_o;
  logic [ACT_W-1:0]  match_action;
  logic [ID_W-1:0]   match_pkt_id;
  logic              cfg_we;
  logic [ACT_W-1:0]  cfg_idx;
  logic [31:0]       cfg_addr;
  logic              cfg_valid;
  logic              exec_start_o;
  logic [31:0]       exec_start_addr_o;
  logic              exec_done;
  logic              out_valid_o;
  logic              out_ready;
  logic [ID_W-1:0]   out_pkt_id_o;
  logic [1:0]        out_status_o;
  logic [1:0]        dbg_state_o;

  action_dispatcher #(
    .ACT_W(ACT_W), .ID_W(ID_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .match_valid_i(match_valid), .match_ready_o(match_ready_o),
    .match_action_i(match_action), .match_pkt_id_i(match_pkt_id),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_addr_i(cfg_addr), .cfg_valid_i(cfg_valid),
    .exec_start_o(exec_start_o), .exec_start_addr_o(exec_start_addr_o), .exec_done_i(exec_done),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .out_pkt_id_o(out_pkt_id_o), .out_status_o(out_status_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [ID_W+1:0] exp_q[$];
  logic [31:0]     exp_addr_q[$];
  logic [31:0]     tbl_addr_m [1<<ACT_W];
  logic [(1<<ACT_W)-1:0] tbl_valid_m = '0;

  // executor model controls: 0 normal, 1 done stuck low, 2 done sticks high once raised
  int exec_mode  = 0;
  int exec_delay = 20;
  bit rand_delay = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- executor model ----------------
  initial begin
    int cnt;
    int lowcnt;
    cnt = 0;
    lowcnt = 0;
    exec_done = 1'b0;
    forever begin
      @(negedge clk);
      if (exec_mode == 1) begin
        exec_done = 1'b0;
        cnt = 0;
        lowcnt = 0;
      end else if (!exec_done) begin
        lowcnt = 0;
        if (exec_start_o) begin
          cnt++;
          if (cnt >= exec_delay) exec_done = 1'b1;
        end else begin
          cnt = 0;
        end
      end else if (exec_mode == 0 && !exec_start_o) begin
        lowcnt++;
        if (lowcnt >= 2) begin
          exec_done = 1'b0;
          cnt = 0;
          lowcnt = 0;
          if (rand_delay) exec_delay = $urandom_range(1, 8);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_start;
    logic prev_done;
    logic [31:0] held;
    logic addr_bad;
    int run;
    prev_start = 1'b0;
    prev_done  = 1'b0;
    held = '0;
    addr_bad = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_start = 1'b0;
        prev_done  = 1'b0;
        run = 0;
      end else begin
        if (prev_start && prev_done) check("start_drop_after_done", exec_start_o, 1'b0);
        if (exec_start_o && !prev_start) begin
          if (exp_addr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_start actual=start addr %0h required=no start", exec_start_addr_o);
          end else begin
            held = exp_addr_q.pop_front();
            check("start_addr", exec_start_addr_o, held);
          end
          addr_bad = 1'b0;
          run = 0;
        end
        if (exec_start_o) begin
          run++;
          if (exec_start_addr_o !== held) addr_bad = 1'b1;
        end
        if (!exec_start_o && prev_start) begin
          check("addr_held_stable", addr_bad, 1'b0);
          if (exec_mode == 1) check("wait_timeout_len", run, TIMEOUT);
        end
        if (out_valid_o && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out actual=pkt %0h status %0h required=no record", out_pkt_id_o, out_status_o);
          end else begin
            check("out_record", {out_pkt_id_o, out_status_o}, exp_q.pop_front());
          end
        end
        prev_start = exec_start_o;
        prev_done  = exec_done;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic [ACT_W-1:0] idx, input logic [31:0] addr, input logic vld);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_idx = idx;
    cfg_addr = addr;
    cfg_valid = vld;
    tbl_addr_m[idx] = addr;
    tbl_valid_m[idx] = vld;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // exec_st is the outcome the executor scenario should produce if the entry is valid
  task automatic push(input logic [ACT_W-1:0] act, input logic [ID_W-1:0] id, input logic [1:0] exec_st);
    int t;
    logic [1:0] st;
    @(negedge clk);
    match_valid = 1'b1;
    match_action = act;
    match_pkt_id = id;
    t = 0;
    while (!match_ready_o && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!match_ready_o) begin
      check("push_ready_timeout", match_ready_o, 1'b1);
    end else begin
      if (tbl_valid_m[act]) begin
        exp_addr_q.push_back(tbl_addr_m[act]);
        st = exec_st;
      end else begin
        st = 2'b01;
      end
      exp_q.push_back({id, st});
    end
    @(negedge clk);
    match_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("drain_records_left", exp_q.size(), 0);
    check("drain_starts_left", exp_addr_q.size(), 0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_exec_start", exec_start_o, 1'b0);
    check("rst_exec_addr", exec_start_addr_o, 32'h0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_pkt_id", out_pkt_id_o, 8'h0);
    check("rst_out_status", out_status_o, 2'b00);
    check("rst_match_ready", match_ready_o, 1'b1);
    check("rst_state_idle", dbg_state_o, 2'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst = 1'b1;
    match_valid = 1'b0;
    match_action = '0;
    match_pkt_id = '0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_addr = '0;
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // normal run, plus a table rewrite of the in-use entry while started
    cfg_write(4'd3, 32'h0000_0100, 1'b1);
    push(4'd3, 8'h21, 2'b00);
    @(negedge clk);
    #1;
    check("start_latency", exec_start_o, 1'b1);
    cfg_write(4'd3, 32'h0000_0200, 1'b1);
    drain(2000);

    // invalid entry
    push(4'd5, 8'h35, 2'b00);
    t = 1;
    @(negedge clk);
    #1;
    while (!out_valid_o && t < 4) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("no_action_latency_ok", (t <= 3), 1'b1);
    drain(100);

    // FIFO full under backpressure
    exec_delay = 3;
    cfg_write(4'd7, 32'h0000_0700, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push((i % 2) ? 4'd7 : 4'd3, 8'h60 + 8'(i), 2'b00);
    repeat (3) @(negedge clk);
    #1;
    check("fifo_full_ready_low", match_ready_o, 1'b0);
    check("backpressure_out_held", out_valid_o, 1'b1);
    fork
      push(4'd7, 8'h65, 2'b00);
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain(2000);

    // done stuck low: WAIT_DONE timeout, then a normal dispatch
    exec_mode = 1;
    push(4'd3, 8'h40, 2'b10);
    drain(5000);
    exec_mode = 0;
    push(4'd7, 8'h41, 2'b00);
    drain(2000);

    // done never releases: RELEASE timeout, then recovery
    exec_delay = 5;
    exec_mode = 2;
    push(4'd3, 8'h50, 2'b10);
    drain(5000);
    exec_mode = 0;
    repeat (5) @(negedge clk);
    push(4'd3, 8'h51, 2'b00);
    drain(2000);

    // reset while waiting on the executor
    exec_delay = 40;
    push(4'd7, 8'h66, 2'b00);
    t = 0;
    while (!exec_start_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("pre_reset_started", exec_start_o, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    tbl_valid_m = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals();
    push(4'd3, 8'h67, 2'b00);
    drain(200);

    // random traffic
    rand_delay = 1'b1;
    for (int i = 0; i < (1 << ACT_W); i++)
      cfg_write(ACT_W'(i), $urandom, 1'($urandom_range(0, 1)));
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(ACT_W'($urandom_range(0, (1 << ACT_W) - 1)), ID_W'($urandom_range(0, 255)), 2'b00);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(20000);
    rand_ready = 1'b0;
    out_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
